instr_sequencer: RTL
====================

# instr_sequencer

Program-memory-backed instruction issuer that drives the 20-bit instruction port of `simple_cpu`. It replaces hand-timed instruction stimulus with a real fetch/issue engine. The block supports:
- a host-side load port that fills a small instruction store;
- start/abort control;
- a valid/ready handshake that holds each instruction stable until the CPU accepts it.

It sits between the host/loader and the CPU in the top-level integration.

## Interface
- `INSTR_WIDTH`, default 20: instruction width; must match the CPU.
- `PC_BITS`, default 4: program address width; store depth = 2**PC_BITS.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: write strobe for the program store.
- `load_addr` in PC_BITS: program store write address.
- `load_data` in INSTR_WIDTH: program store write data.
- `start` in 1: begin execution at address 0 (single-cycle pulse or level).
- `abort` in 1: stop issuing and return to IDLE.
- `instr_ready` in 1: CPU can accept a new instruction this cycle.
- `instruction` out INSTR_WIDTH: instruction offered to the CPU (registered).
- `instr_valid` out 1: `instruction` is a new, unaccepted instruction.
- `pc` out PC_BITS: address of the instruction currently fetched/offered.
- `busy` out 1: high in FETCH or ISSUE.
- `done` out 1: high in HALTED.
- `issue_cnt` out 8: instructions accepted since last start, saturates at 255.

## Operation
- **Program store:** 2**PC_BITS x INSTR_WIDTH registers, cleared to all-zero by reset.
- **Load port:** write on `load_en` only in IDLE or HALTED; ignored in FETCH/ISSUE.
- **Halt marker:** bits[19:18] == 2'b00 is a HALT marker. It is never issued. A cleared store therefore halts immediately.
- **FSM states:** IDLE, FETCH, ISSUE, HALTED.
- **IDLE/HALTED + start:**
  - go to FETCH;
  - `pc` <= 0, `issue_cnt` <= 0, `instr_valid` stays 0.
- **FETCH:** read mem[pc].
  - If HALT marker: go to HALTED; `instruction` unchanged.
  - Else: `instruction` <= mem[pc], `instr_valid` <= 1, go to ISSUE.
- **ISSUE:** hold `instruction` and `instr_valid` stable while `instr_ready`=0.
- **Transfer (`instr_valid` & `instr_ready` at an edge):**
  - `instr_valid` <= 0;
  - `issue_cnt` increments (saturating);
  - if `pc` == 2**PC_BITS-1: go to HALTED, `pc` holds;
  - else `pc` <= pc+1 and go to FETCH.
- **After transfer:** `instruction` keeps the last issued value until the next FETCH completes, so the CPU can execute multi-cycle from a stable bus.
- **abort (any state):** go to IDLE at the next edge; `instr_valid` <= 0; `pc`, `instruction`, `issue_cnt` hold.
  - If abort and a transfer coincide, the transfer counts (`issue_cnt`++) and the state still goes to IDLE.
- **start outside IDLE/HALTED:** ignored.
- **Simultaneous load and start in IDLE:** the write lands first, and FETCH of address 0 sees the new data.

## Timing
- **Reset values:**
  - state IDLE;
  - `instruction` 0, `instr_valid` 0, `pc` 0;
  - `busy` 0, `done` 0, `issue_cnt` 0.
- **Reset mid-operation:** the asynchronous assert clears everything immediately, including an in-flight offer.
- **Start latency:** start sampled at edge E0; FETCH during E0–E1; `instr_valid`=1 and new `instruction` from E1.
- **Throughput:** a transfer at edge Ek gives FETCH during Ek–Ek+1 and the next `instr_valid` from Ek+1. Maximum rate is 1 instruction per 2 cycles; `instr_valid` is low for at least one cycle between offers.
- **Output behaviour:** `busy` and `done` are decoded from the state register (glitch-free, registered state). `instr_ready` has no combinational path to any output.

## Configuration
- **`SEQ_WRAP_EN` defined:** a transfer at the last address sets `pc` <= 0 and returns to FETCH. Execution loops until a HALT marker or abort.
- **`SEQ_WRAP_EN` undefined:** the last-address transfer goes to HALTED (behaviour above).
- **Either way:** the HALT marker always halts, and `issue_cnt` saturation is unchanged.

## Test plan
- **Basic run:**
  - Stimulus: load mem[0]=20'b01000111000000000000, mem[1]=20'b01010011000000000000, mem[2]=20'b01110010000000000001, mem[3]=0; `instr_ready`=1; pulse start.
  - Response: three offers in order, valid first seen 1 cycle after start, with ≥1 idle cycle between offers; then `done`=1, `pc`=3, `issue_cnt`=3.
- **Backpressure:**
  - Stimulus: hold `instr_ready`=0 for 5 cycles during ISSUE of mem[1].
  - Response: `instruction`=20'b01010011000000000000 and `instr_valid`=1 stable every cycle; `pc`=1; no count change until `instr_ready` rises.
- **Full store, no HALT marker, `instr_ready`=1:**
  - Stimulus: all 16 words non-HALT (e.g. 20'b11011000000011110000).
  - Response without `SEQ_WRAP_EN`: 16 issues, then HALTED, `issue_cnt`=16, `pc`=15.
  - Response with `SEQ_WRAP_EN`: the 17th offer comes from `pc`=0; abort after 300 issues gives `issue_cnt`=255 (saturated).
- **Abort during ISSUE:** stimulus abort with `instr_ready`=0 → next cycle IDLE, `instr_valid`=0, `busy`=0; restart re-executes from `pc`=0 with `issue_cnt` cleared.
- **Load while busy:** stimulus `load_en` to the current `pc`+1 during ISSUE → write ignored; the original word is issued next.
- **Async reset mid-ISSUE:** stimulus assert `rst` between edges → `instr_valid`, `instruction`, `pc` go to 0 immediately; the store reads all zero, so the next start halts with `issue_cnt`=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Program-memory-backed instruction issuer for simple_cpu. A host fills a
// small instruction store through the load port. On start, the block fetches
// words from address 0 and offers each one to the CPU over a valid/ready
// handshake, holding the offer stable until it is accepted. A word whose top
// two bits are 2'b00 is a HALT marker: it is never issued and stops the run.
//
// Optional feature (compile-time macro SEQ_WRAP_EN):
//   defined   - a transfer at the last store address wraps pc to 0 and
//               keeps fetching until a HALT marker or an abort.
//   undefined - a transfer at the last store address ends in HALTED.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst          in   asynchronous active-high reset
//   load_en      in   program store write strobe (honoured in IDLE/HALTED)
//   load_addr    in   program store write address
//   load_data    in   program store write data
//   start        in   begin execution at address 0 (from IDLE/HALTED)
//   abort        in   stop issuing, return to IDLE
//   instr_ready  in   CPU accepts the offered instruction this cycle
//   instruction  out  registered instruction offered to the CPU
//   instr_valid  out  instruction is new and not yet accepted
//   pc           out  address of the instruction fetched/offered
//   busy         out  in FETCH or ISSUE
//   done         out  in HALTED
//   issue_cnt    out  instructions accepted since last start, saturates at 255
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned INSTR_WIDTH = 20,
    parameter int unsigned PC_BITS     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             issue_cnt
);

    localparam int unsigned        Depth  = 2 ** PC_BITS;
    localparam logic [PC_BITS-1:0] LastPc = PC_BITS'(Depth - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StHalted
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [INSTR_WIDTH-1:0] mem [Depth];

    logic [INSTR_WIDTH-1:0] fetch_word;
    logic                   is_halt;
    logic                   load_ok;
    logic                   transfer;
    logic [7:0]             cnt_inc;

    assign fetch_word = mem[pc_q];
    assign is_halt    = (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00);
    // Loads are only accepted while nothing is being fetched or offered.
    assign load_ok    = load_en && ((state_q == StIdle) || (state_q == StHalted));
    assign transfer   = valid_q && instr_ready;
    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Program store. A write in the same cycle as start lands at that edge,
    // so the following FETCH of address 0 already sees the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        if (abort) begin
            // An acceptance on the same edge as abort still counts.
            state_d = StIdle;
            valid_d = 1'b0;
            if (transfer) begin
                cnt_d = cnt_inc;
            end
        end else begin
            unique case (state_q)
                StIdle, StHalted: begin
                    if (start) begin
                        state_d = StFetch;
                        pc_d    = '0;
                        cnt_d   = 8'd0;
                    end
                end
                StFetch: begin
                    if (is_halt) begin
                        // The last issued word stays on the bus.
                        state_d = StHalted;
                    end else begin
                        instr_d = fetch_word;
                        valid_d = 1'b1;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (transfer) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_inc;
                        if (pc_q == LastPc) begin
`ifdef SEQ_WRAP_EN
                            pc_d    = '0;
                            state_d = StFetch;
`else
                            state_d = StHalted;
`endif
                        end else begin
                            pc_d    = pc_q + PC_BITS'(1);
                            state_d = StFetch;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign issue_cnt   = cnt_q;
    assign busy        = (state_q == StFetch) || (state_q == StIssue);
    assign done        = (state_q == StHalted);

endmodule
